// File: rtl/mul_div_seq.sv
// Multi-cycle RV32 M-extension unit: single-cycle registered multiply and a
// 32-iteration restoring divider, with a one-cycle result pulse back to EX.
module mul_div_seq #(
  parameter bit SPECIAL_FAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic [31:0] mul_div_out,
  output logic        mul_div_ready
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [31:0] w_out_d;

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic [4:0]  r_cnt;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_sel_rem;
  logic        r_spec;
  logic [31:0] r_spec_res;
  logic [31:0] r_out;
  logic        r_ready;
  logic        r_busy;

  // Multiply: sign-extend to 64 bits so a plain 64-bit product covers all variants.
  logic        w_a_sgn;
  logic        w_b_sgn;
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_prod;
  logic [31:0] w_mul_res;

  assign w_a_sgn   = (op == 3'd1) || (op == 3'd2);
  assign w_b_sgn   = (op == 3'd1);
  assign w_a64     = {{32{w_a_sgn & rs1[31]}}, rs1};
  assign w_b64     = {{32{w_b_sgn & rs2[31]}}, rs2};
  assign w_prod    = w_a64 * w_b64;
  assign w_mul_res = (op[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];

  // Divide operand preparation; op[0] marks unsigned, op[1] selects remainder.
  logic        w_div_sgn;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic        w_div0;
  logic        w_ovf;
  logic        w_spec;
  logic [31:0] w_spec_res;

  assign w_div_sgn  = !op[0];
  assign w_a_neg    = w_div_sgn & rs1[31];
  assign w_b_neg    = w_div_sgn & rs2[31];
  assign w_a_abs    = w_a_neg ? -rs1 : rs1;
  assign w_b_abs    = w_b_neg ? -rs2 : rs2;
  assign w_div0     = (rs2 == 32'd0);
  assign w_ovf      = w_div_sgn && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign w_spec     = w_div0 || w_ovf;
  assign w_spec_res = w_div0 ? (op[1] ? rs1 : 32'hFFFF_FFFF)
                             : (op[1] ? 32'd0 : 32'h8000_0000);

  // One restoring step; r_rem[31] is the bit shifted out, so the trial always fits.
  logic [31:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic [31:0] w_div_res;

  assign w_shift   = {r_rem[30:0], r_quo[31]};
  assign w_ge      = r_rem[31] || (w_shift >= r_div);
  assign w_sub     = w_shift - r_div;
  assign w_rem_nx  = w_ge ? w_sub : w_shift;
  assign w_quo_nx  = {r_quo[30:0], w_ge};
  assign w_q_fix   = r_neg_q ? -w_quo_nx : w_quo_nx;
  assign w_r_fix   = r_neg_r ? -w_rem_nx : w_rem_nx;
  assign w_div_res = r_spec ? r_spec_res : (r_sel_rem ? w_r_fix : w_q_fix);

  logic w_accept;
  assign w_accept = (r_state == StIdle) && req_valid && !flush;

  always_comb begin
    w_state_d = r_state;
    w_out_d   = r_out;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (!op[2]) begin
            w_state_d = StDone;
            w_out_d   = w_mul_res;
          end else if (SPECIAL_FAST && w_spec) begin
            w_state_d = StDone;
            w_out_d   = w_spec_res;
          end else begin
            w_state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (flush) begin
          w_state_d = StIdle;
        end else if (r_cnt == 5'd31) begin
          w_state_d = StDone;
          w_out_d   = w_div_res;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_out   <= 32'd0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_out   <= w_out_d;
      r_ready <= (w_state_d == StDone);
      r_busy  <= (w_state_d == StBusy);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem      <= 32'd0;
      r_quo      <= 32'd0;
      r_div      <= 32'd0;
      r_cnt      <= 5'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_sel_rem  <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_res <= 32'd0;
    end else if (w_accept && op[2]) begin
      r_rem      <= 32'd0;
      r_quo      <= w_a_abs;
      r_div      <= w_b_abs;
      r_cnt      <= 5'd0;
      r_neg_q    <= w_a_neg ^ w_b_neg;
      r_neg_r    <= w_a_neg;
      r_sel_rem  <= op[1];
      r_spec     <= w_spec;
      r_spec_res <= w_spec_res;
    end else if (r_state == StBusy) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt + 5'd1;
    end
  end

  assign stall         = !rst && (w_accept || (r_state == StBusy));
  assign busy          = r_busy;
  assign mul_div_out   = r_out;
  assign mul_div_ready = r_ready;

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed bench for mul_div_seq; a fast-special and a slow-special instance
// share all inputs so both special-case timings are observed side by side.
module tb_mul_div_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;

  logic        stall_f, busy_f, rdy_f;
  logic [31:0] out_f;
  logic        stall_s, busy_s, rdy_s;
  logic [31:0] out_s;

  int n_err;
  int n_chk;

  int          lat_f, lat_s, bsy_f, bsy_s;
  logic [31:0] val_f, val_s;
  logic        st_t, st_t1;

  mul_div_seq #(.SPECIAL_FAST(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .stall(stall_f), .busy(busy_f), .mul_div_out(out_f),
    .mul_div_ready(rdy_f)
  );

  mul_div_seq #(.SPECIAL_FAST(1'b0)) dut_slow (
    .clk(clk), .rst(rst), .req_valid(req_valid), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .stall(stall_s), .busy(busy_s), .mul_div_out(out_s),
    .mul_div_ready(rdy_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  // Issue one instruction at cycle T and record first-pulse latency per instance.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs1 = a; rs2 = b; req_valid = 1'b1;
    #1;
    st_t = stall_f;
    st_t1 = 1'b1;
    lat_f = 0; lat_s = 0; bsy_f = 0; bsy_s = 0; val_f = '0; val_s = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) st_t1 = stall_f;
      if (busy_f && lat_f == 0) bsy_f++;
      if (busy_s && lat_s == 0) bsy_s++;
      if (rdy_f && lat_f == 0) begin lat_f = k; val_f = out_f; end
      if (rdy_s && lat_s == 0) begin lat_s = k; val_s = out_s; end
      if (lat_f != 0 && lat_s != 0) break;
    end
    req_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd5; flush = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL rst_stall_f: got %b expected 0", stall_f); end
    n_chk++; if (stall_s !== 1'b0) begin n_err++; $display("FAIL rst_stall_s: got %b expected 0", stall_s); end
    n_chk++; if (busy_f !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy_f); end
    n_chk++; if (rdy_f !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b expected 0", rdy_f); end
    n_chk++; if (out_f !== 32'd0) begin n_err++; $display("FAIL rst_out: got %h expected 0", out_f); end
    n_chk++; if (rdy_s !== 1'b0) begin n_err++; $display("FAIL rst_ready_s: got %b expected 0", rdy_s); end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    n_chk++; if (val_f !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_val: got %h expected ffffffeb", val_f); end
    n_chk++; if (lat_f !== 1) begin n_err++; $display("FAIL mul_lat: got %0d expected 1", lat_f); end
    n_chk++; if (st_t !== 1'b1) begin n_err++; $display("FAIL mul_stall_T: got %b expected 1", st_t); end
    n_chk++; if (st_t1 !== 1'b0) begin n_err++; $display("FAIL mul_stall_T1: got %b expected 0", st_t1); end
    n_chk++; if (val_s !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mul_val_s: got %h expected ffffffeb", val_s); end
  endtask

  task automatic test_mulh();
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    n_chk++; if (val_f !== 32'h4000_0000) begin n_err++; $display("FAIL mulh_val: got %h expected 40000000", val_f); end
    n_chk++; if (lat_f !== 1) begin n_err++; $display("FAIL mulh_lat: got %0d expected 1", lat_f); end
    run_op(3'd3, 32'h8000_0000, 32'h8000_0000);
    n_chk++; if (val_f !== 32'h4000_0000) begin n_err++; $display("FAIL mulhu_val: got %h expected 40000000", val_f); end
    run_op(3'd2, 32'h8000_0000, 32'd2);
    n_chk++; if (val_f !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulhsu_val: got %h expected ffffffff", val_f); end
    run_op(3'd3, 32'hFFFF_FFFF, 32'd2);
    n_chk++; if (val_f !== 32'h0000_0001) begin n_err++; $display("FAIL mulhu_small: got %h expected 00000001", val_f); end
  endtask

  task automatic test_div();
    run_op(3'd4, 32'hFFFF_FFEC, 32'd6);
    n_chk++; if (val_f !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_val: got %h expected fffffffd", val_f); end
    n_chk++; if (lat_f !== 33) begin n_err++; $display("FAIL div_lat: got %0d expected 33", lat_f); end
    n_chk++; if (bsy_f !== 32) begin n_err++; $display("FAIL div_busy_cycles: got %0d expected 32", bsy_f); end
    n_chk++; if (st_t1 !== 1'b1) begin n_err++; $display("FAIL div_stall_T1: got %b expected 1", st_t1); end
    run_op(3'd6, 32'hFFFF_FFEC, 32'd6);
    n_chk++; if (val_f !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL rem_val: got %h expected fffffffe", val_f); end
    n_chk++; if (val_s !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL rem_val_s: got %h expected fffffffe", val_s); end
    run_op(3'd7, 32'd100, 32'd7);
    n_chk++; if (val_f !== 32'd2) begin n_err++; $display("FAIL remu_val: got %h expected 00000002", val_f); end
  endtask

  task automatic test_special();
    run_op(3'd5, 32'h1234_5678, 32'd0);
    n_chk++; if (val_f !== 32'hFFFF_FFFF || lat_f !== 1) begin n_err++; $display("FAIL divu_zero_fast: got %h@%0d expected ffffffff@1", val_f, lat_f); end
    n_chk++; if (val_s !== 32'hFFFF_FFFF || lat_s !== 33) begin n_err++; $display("FAIL divu_zero_slow: got %h@%0d expected ffffffff@33", val_s, lat_s); end
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    n_chk++; if (val_f !== 32'd0 || lat_f !== 1) begin n_err++; $display("FAIL rem_ovf_fast: got %h@%0d expected 00000000@1", val_f, lat_f); end
    n_chk++; if (val_s !== 32'd0 || lat_s !== 33) begin n_err++; $display("FAIL rem_ovf_slow: got %h@%0d expected 00000000@33", val_s, lat_s); end
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    n_chk++; if (val_f !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_fast: got %h expected 80000000", val_f); end
    n_chk++; if (val_s !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_slow: got %h expected 80000000", val_s); end
    run_op(3'd4, 32'hFFFF_FFEC, 32'd0);
    n_chk++; if (val_s !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_zero_neg_slow: got %h expected ffffffff", val_s); end
    run_op(3'd6, 32'hFFFF_FFEC, 32'd0);
    n_chk++; if (val_f !== 32'hFFFF_FFEC) begin n_err++; $display("FAIL rem_zero_fast: got %h expected ffffffec", val_f); end
    n_chk++; if (val_s !== 32'hFFFF_FFEC) begin n_err++; $display("FAIL rem_zero_slow: got %h expected ffffffec", val_s); end
  endtask

  task automatic test_flush();
    int pulses;
    pulses = 0;
    op = 3'd4; rs1 = 32'hFFFF_FFEC; rs2 = 32'd6; req_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (rdy_f || rdy_s) pulses++;
    end
    flush = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (busy_f !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b expected 0", busy_f); end
    n_chk++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b expected 0", stall_f); end
    if (rdy_f || rdy_s) pulses++;
    flush = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (rdy_f || rdy_s) pulses++;
    end
    n_chk++; if (pulses !== 0) begin n_err++; $display("FAIL flush_no_pulse: got %0d expected 0", pulses); end
    run_op(3'd5, 32'd100, 32'd7);
    n_chk++; if (val_f !== 32'd14 || lat_f !== 33) begin n_err++; $display("FAIL flush_then_divu: got %h@%0d expected 0000000e@33", val_f, lat_f); end
  endtask

  task automatic test_reset_mid();
    op = 3'd4; rs1 = 32'hFFFF_FFEC; rs2 = 32'd6; req_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_chk++; if (busy_f !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b expected 1", busy_f); end
    rst = 1'b1;
    #1;
    n_chk++; if (busy_f !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b expected 0", busy_f); end
    n_chk++; if (stall_f !== 1'b0) begin n_err++; $display("FAIL mid_rst_stall: got %b expected 0", stall_f); end
    n_chk++; if (rdy_f !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b expected 0", rdy_f); end
    n_chk++; if (out_f !== 32'd0) begin n_err++; $display("FAIL mid_rst_out: got %h expected 0", out_f); end
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(3'd0, 32'd3, 32'd4);
    n_chk++; if (val_f !== 32'd12 || lat_f !== 1) begin n_err++; $display("FAIL post_rst_mul: got %h@%0d expected 0000000c@1", val_f, lat_f); end
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_div_seq.md
# mul_div_seq

Multi-cycle M-extension execution sequencer for the RV32 core's EX stage. It accepts one MUL/DIV/REM instruction at a time from EX and holds the pipeline with a stall while it works. Multiplies are computed with a registered product; divides and remainders use an internal 32-iteration restoring divider. The result is returned on `mul_div_out` with a one-cycle `mul_div_ready` pulse, which is the pair the jump unit muxes onto the writeback path.

## Interface
- `SPECIAL_FAST`, default 1: when 1, divide-by-zero and signed overflow finish in 1 cycle. When 0, they run the full 32 iterations but still produce the same spec'd values.
- `clk`, in, 1: core clock. All state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req_valid`, in, 1: EX holds an M-extension instruction. Stays high for that instruction until the `mul_div_ready` cycle.
- `op`, in, 3: funct3 encoding. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1`, in, 32: operand A (dividend or multiplicand).
- `rs2`, in, 32: operand B (divisor or multiplier).
- `flush`, in, 1: branch/trap kill. Aborts any in-flight operation.
- `stall`, out, 1: freezes IF/ID/EX. Combinational.
- `busy`, out, 1: registered; high while in state BUSY.
- `mul_div_out`, out, 32: result. Valid only when `mul_div_ready`=1.
- `mul_div_ready`, out, 1: registered one-cycle result-valid pulse.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE: an operation is accepted when `req_valid`=1 and `flush`=0. Operands and `op` are latched on acceptance.
  - MUL family: the 64-bit product is registered and the FSM goes to DONE.
  - MUL selects product[31:0]; MULH, MULHSU and MULHU select product[63:32].
  - Sign handling: MULH is signed×signed, MULHSU is signed×unsigned, MULHU is unsigned×unsigned.
  - DIV/REM family, special case (when `SPECIAL_FAST`=1): the result is loaded directly and the FSM goes to DONE.
  - DIV/REM family, otherwise: the FSM loads |A|, |B|, sign flags and count=0, then goes to BUSY.
- BUSY: each cycle performs one restoring step (shift the remainder left, trial-subtract, set the quotient bit) and increments count.
  - When count reaches 31, that cycle's step completes and the FSM goes to DONE.
- DONE: `mul_div_ready`=1 and `mul_div_out` holds the result. The FSM returns to IDLE next edge.
  - `req_valid` is ignored in DONE, because the same instruction is still in EX.
- Sign fix-up is applied when leaving BUSY.
  - Quotient is negated iff sign(A)≠sign(B).
  - Remainder takes sign(A).
- Special values:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV/REM): DIV returns 0x80000000, REM returns 0.
- Flush: `flush`=1 in any state forces IDLE on the next edge.
  - No `mul_div_ready` pulse is produced, and the latched result is discarded.
  - If `flush` and `req_valid` are both high in IDLE, flush wins and nothing is accepted.
  - A flush in the DONE cycle does not suppress that cycle's pulse, which is already registered. The pipeline ignores it.
- `stall` = (IDLE & `req_valid` & !`flush`) | BUSY. It is low in DONE so EX advances.

## Timing
- Reset values: state IDLE, `busy`=0, `mul_div_ready`=0, `mul_div_out`=0, count=0. `stall`=0 while `rst`=1.
- Cycle T is the acceptance cycle (IDLE with `req_valid`=1); `stall`=1 in T.
- MUL family: `mul_div_ready` at T+1. Total EX occupancy is 2 cycles.
- DIV/REM, normal path: BUSY for T+1..T+32, `mul_div_ready` at T+33. Total 34 cycles.
- DIV/REM special case with `SPECIAL_FAST`=1: `mul_div_ready` at T+1.
- Back-to-back operations: the next instruction can be accepted at the earliest in the cycle after DONE.
- `mul_div_out` holds its last value outside DONE. Consumers qualify it with `mul_div_ready`.
- Asynchronous `rst` mid-BUSY: immediate return to IDLE with all outputs at their reset values and no pulse.

## Test plan
- MUL: A=7, B=−3 (0xFFFFFFFD), op 0, at T → `mul_div_out`=0xFFFFFFEB with ready at T+1; `stall` high only in T.
- MULH/MULHU: A=0x80000000, B=0x80000000 → MULH=0x40000000, MULHU=0x40000000. MULHSU with B=2 → 0xFFFFFFFF.
- DIV: A=−20, B=6 → quotient −3 (0xFFFFFFFD) with ready at T+33, and `busy` high for exactly 32 cycles. REM on the same operands → 0xFFFFFFFE (−2).
- Specials: DIVU with B=0 → 0xFFFFFFFF at T+1. REM with A=0x80000000, B=−1 → 0 at T+1. With `SPECIAL_FAST`=0, the same values appear at T+33.
- Flush: start DIV, assert `flush` at T+10 → IDLE at T+11, no ready pulse ever. Then a new DIVU with A=100, B=7 → 14 at its own T+33.
- Reset mid-op: assert `rst` at T+5 of a DIV → `busy`, `stall` and `mul_div_ready` drop to 0 immediately. After release, a MUL 3×4 → 12 at T+1.
